// File: rtl/poly_bram_ctrl.sv
// rtl/poly_bram_ctrl.sv - LOAD/READ sequencer for a 64x512 coefficient BRAM
//
// Owns BRAM port A (synchronous write) and port B (combinational read) for the
// polynomial core. One job at a time:
//   LOAD : accepts s_data over s_valid/s_ready, writes consecutive addresses.
//   READ : streams a contiguous range out over m_valid/m_ready through one
//          output register stage, with full backpressure.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   load_start, read_start one-cycle job requests (load wins on a tie)
//   base, len              start address and word count (1..DEPTH)
//   s_valid/s_data/s_ready load stream slave
//   m_valid/m_data/m_last/m_ready  read stream master
//   busy, done, err        status: job active, completion pulse, bad-len pulse
//   bram_wea/addra/dina    BRAM write port
//   bram_addrb/doutb       BRAM read port (doutb combinational from addrb)

module poly_bram_ctrl #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load_start,
  input  logic              read_start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              bram_wea,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dina,
  output logic [ADDR_W-1:0] bram_addrb,
  input  logic [DATA_W-1:0] bram_doutb
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_READ = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  state_t              state_q, state_d;
  // ptr wraps naturally at DEPTH because DEPTH == 2**ADDR_W.
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  // Words still to write (LOAD) or still to issue into the output stage (READ).
  logic [ADDR_W:0]     rem_q, rem_d;
  logic                m_valid_q, m_valid_d;
  logic                m_last_q, m_last_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                len_ok;
  logic                wr_fire;
  logic                rd_load;
  logic                rd_hs;

  assign len_ok  = (len != '0) && (len <= DEPTH_L);
  // Gated by resetn so a write in flight is suppressed in the reset cycle.
  assign wr_fire = resetn && (state_q == S_LOAD) && s_valid;
  // Output register can take a new word when empty or draining this cycle.
  assign rd_load = (state_q == S_READ) && (!m_valid_q || m_ready) && (rem_q != '0);
  assign rd_hs   = m_valid_q && m_ready;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_start || read_start) begin
          if (!len_ok) begin
            err_d = 1'b1;
          end else begin
            state_d = load_start ? S_LOAD : S_READ;
            ptr_d   = base;
            rem_d   = len;
          end
        end
      end

      S_LOAD: begin
        if (s_valid) begin
          ptr_d = ptr_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == ONE_L) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      S_READ: begin
        if (rd_load) begin
          m_data_d  = bram_doutb;
          m_valid_d = 1'b1;
          m_last_d  = (rem_q == ONE_L);
          ptr_d     = ptr_q + 1'b1;
          rem_d     = rem_q - 1'b1;
        end else if (rd_hs) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
        end
        // Last word leaves the register: nothing left to issue, so rd_load
        // is false and the branch above has already cleared m_valid.
        if (rd_hs && m_last_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      rem_q     <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign s_ready    = (state_q == S_LOAD);
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_last     = m_last_q;
  assign bram_wea   = wr_fire;
  assign bram_addra = ptr_q;
  assign bram_dina  = s_data;
  assign bram_addrb = ptr_q;

endmodule
